// File: rtl/cache_pkg.sv
// Shared cache/backing-memory definitions: geometry, default latencies and
// the refill-controller state encoding.
package cache_pkg;

  localparam int unsigned PA_WIDTH   = 16;
  localparam int unsigned BLK_WIDTH  = 128;
  localparam int unsigned BOFF_BITS  = 4;
  localparam int unsigned MEM_BLOCKS = 1024;
  localparam int unsigned WR_LAT_DEF = 4;
  localparam int unsigned RD_LAT_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WB   = 2'd1,
    RD   = 2'd2,
    RESP = 2'd3
  } mem_state_t;

  // Latency counter width; never narrower than one bit so a 1-cycle phase still has a register.
  function automatic int unsigned lat_cnt_w(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m <= 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/mem_blk_array.sv
// Single-port block-granular backing store with a registered read port.
// Read-before-write on a same-cycle access; contents are not reset.
module mem_blk_array
  import cache_pkg::*;
#(
  parameter int unsigned DEPTH = MEM_BLOCKS,
  parameter int unsigned WIDTH = BLK_WIDTH,
  parameter int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] idx,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[idx] <= wdata;
    end
    r_rdata <= r_mem[idx];
  end

  assign rdata = r_rdata;

endmodule

// File: rtl/mem_refill_ctrl.sv
// Miss-servicing stage: optional dirty-victim write-back followed by an optional
// block refill, each with a fixed latency, finished by a one-cycle response.
module mem_refill_ctrl
  import cache_pkg::*;
#(
  parameter int unsigned WR_LAT = WR_LAT_DEF,
  parameter int unsigned RD_LAT = RD_LAT_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_rd,
  input  logic                 req_wb,
  input  logic [PA_WIDTH-1:0]  rd_addr,
  input  logic [PA_WIDTH-1:0]  wb_addr,
  input  logic [BLK_WIDTH-1:0] wb_blk,
  output logic                 resp_valid,
  output logic [BLK_WIDTH-1:0] resp_blk,
  output logic                 busy
);

  localparam int unsigned IDX_W = $clog2(MEM_BLOCKS);
  localparam int unsigned CNT_W = lat_cnt_w(WR_LAT, RD_LAT);

  mem_state_t           r_state;
  mem_state_t           w_state_n;
  logic [CNT_W-1:0]     r_cnt;
  logic [CNT_W-1:0]     w_cnt_n;
  logic                 r_rd;
  logic                 r_wb;
  logic [IDX_W-1:0]     r_rd_idx;
  logic [IDX_W-1:0]     r_wb_idx;
  logic [BLK_WIDTH-1:0] r_wb_blk;
  logic [BLK_WIDTH-1:0] r_resp_blk;
  logic                 r_blk_live;
  logic                 r_req_ready;
  logic                 r_busy;
  logic                 r_resp_valid;

  logic                 w_accept;
  logic                 w_cnt_zero;
  logic                 w_mem_we;
  logic [IDX_W-1:0]     w_mem_idx;
  logic                 w_rd_done;
  logic [BLK_WIDTH-1:0] w_ram_rdata;

  // Byte offset and address bits above the index are intentionally dropped.
  logic w_unused_addr_bits;
  assign w_unused_addr_bits = &{1'b0,
                                rd_addr[BOFF_BITS-1:0], rd_addr[PA_WIDTH-1:BOFF_BITS+IDX_W],
                                wb_addr[BOFF_BITS-1:0], wb_addr[PA_WIDTH-1:BOFF_BITS+IDX_W]};

  assign w_accept   = req_valid & (r_state == IDLE) & (req_rd | req_wb);
  assign w_cnt_zero = (r_cnt == '0);

  // Next-state, counter and RAM control.
  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_mem_we  = 1'b0;
    w_mem_idx = r_rd_idx;
    w_rd_done = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (req_wb) begin
            w_state_n = WB;
            w_cnt_n   = CNT_W'(WR_LAT - 1);
          end else begin
            w_state_n = RD;
            w_cnt_n   = CNT_W'(RD_LAT - 1);
          end
        end
      end
      WB: begin
        w_mem_idx = r_wb_idx;
        if (w_cnt_zero) begin
          w_mem_we = 1'b1;
          if (r_rd) begin
            w_state_n = RD;
            w_cnt_n   = CNT_W'(RD_LAT - 1);
          end else begin
            w_state_n = RESP;
          end
        end else begin
          w_cnt_n = r_cnt - CNT_W'(1);
        end
      end
      RD: begin
        if (w_cnt_zero) begin
          w_rd_done = 1'b1;
          w_state_n = RESP;
        end else begin
          w_cnt_n = r_cnt - CNT_W'(1);
        end
      end
      RESP: begin
        w_state_n = IDLE;
      end
      default: begin
        w_state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_req_ready  <= 1'b1;
      r_busy       <= 1'b0;
      r_resp_valid <= 1'b0;
    end else begin
      r_state      <= w_state_n;
      r_cnt        <= w_cnt_n;
      r_req_ready  <= (w_state_n == IDLE);
      r_busy       <= (w_state_n != IDLE);
      r_resp_valid <= (w_state_n == RESP);
    end
  end

  // Request fields are captured once per accepted transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd     <= 1'b0;
      r_wb     <= 1'b0;
      r_rd_idx <= '0;
      r_wb_idx <= '0;
      r_wb_blk <= '0;
    end else if (w_accept) begin
      r_rd     <= req_rd;
      r_wb     <= req_wb;
      r_rd_idx <= rd_addr[BOFF_BITS +: IDX_W];
      r_wb_idx <= wb_addr[BOFF_BITS +: IDX_W];
      r_wb_blk <= wb_blk;
    end
  end

  // The RAM output register carries the refill block during RESP; it is then copied locally to hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_blk_live <= 1'b0;
      r_resp_blk <= '0;
    end else begin
      r_blk_live <= w_rd_done;
      if (r_blk_live) begin
        r_resp_blk <= w_ram_rdata;
      end
    end
  end

  mem_blk_array #(
    .DEPTH (MEM_BLOCKS),
    .WIDTH (BLK_WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (w_mem_we),
    .idx   (w_mem_idx),
    .wdata (r_wb_blk),
    .rdata (w_ram_rdata)
  );

  assign req_ready  = r_req_ready;
  assign busy       = r_busy;
  assign resp_valid = r_resp_valid;
  assign resp_blk   = r_blk_live ? w_ram_rdata : r_resp_blk;

endmodule

// File: tb/tb_mem_refill_ctrl.sv
// Directed bench for mem_refill_ctrl: a transaction table with hand-computed
// latency and refill data, plus reset, null-request and mid-write-back-reset sequences.
module tb_mem_refill_ctrl;
  import cache_pkg::*;

  typedef struct {
    logic                 rd;
    logic                 wb;
    logic [PA_WIDTH-1:0]  rd_addr;
    logic [PA_WIDTH-1:0]  wb_addr;
    logic [BLK_WIDTH-1:0] wb_blk;
    int                   lat;
    logic [BLK_WIDTH-1:0] exp_blk;
  } txn_t;

  localparam logic [BLK_WIDTH-1:0] B_A5   = {4{32'hA5A5A5A5}};
  localparam logic [BLK_WIDTH-1:0] B_DEAD = {32'hDEADBEEF, 96'h0};
  localparam logic [BLK_WIDTH-1:0] B_C3   = {4{32'hC3C3C3C3}};
  localparam logic [BLK_WIDTH-1:0] B_11   = {4{32'h11111111}};
  localparam logic [BLK_WIDTH-1:0] B_22   = {4{32'h22222222}};
  localparam logic [BLK_WIDTH-1:0] B_FF   = {4{32'hFFFF0000}};

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 req_valid = 1'b0;
  logic                 req_ready;
  logic                 req_rd = 1'b0;
  logic                 req_wb = 1'b0;
  logic [PA_WIDTH-1:0]  rd_addr = '0;
  logic [PA_WIDTH-1:0]  wb_addr = '0;
  logic [BLK_WIDTH-1:0] wb_blk = '0;
  logic                 resp_valid;
  logic [BLK_WIDTH-1:0] resp_blk;
  logic                 busy;

  int n_checks = 0;
  int n_errors = 0;

  txn_t vecs [10];

  mem_refill_ctrl u_dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_rd     (req_rd),
    .req_wb     (req_wb),
    .rd_addr    (rd_addr),
    .wb_addr    (wb_addr),
    .wb_blk     (wb_blk),
    .resp_valid (resp_valid),
    .resp_blk   (resp_blk),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [BLK_WIDTH-1:0] act,
                       input logic [BLK_WIDTH-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Control outputs packed as {resp_valid, req_ready, busy}.
  function automatic logic [2:0] ctl();
    return {resp_valid, req_ready, busy};
  endfunction

  // Called just after a falling edge; returns just after the falling edge of the cycle after RESP.
  task automatic run_txn(input txn_t t, input string tag);
    check({tag, "/ready"}, BLK_WIDTH'(ctl()), BLK_WIDTH'(3'b010));
    req_valid = 1'b1;
    req_rd    = t.rd;
    req_wb    = t.wb;
    rd_addr   = t.rd_addr;
    wb_addr   = t.wb_addr;
    wb_blk    = t.wb_blk;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_rd    = ~t.rd;
    req_wb    = ~t.wb;
    rd_addr   = ~t.rd_addr;
    wb_addr   = ~t.wb_addr;
    wb_blk    = ~t.wb_blk;
    for (int k = 0; k <= t.lat + 1; k++) begin
      if (k > 0) @(negedge clk);
      if (k < t.lat) begin
        check($sformatf("%s/ctl_c%0d", tag, k), BLK_WIDTH'(ctl()), BLK_WIDTH'(3'b001));
      end else if (k == t.lat) begin
        check($sformatf("%s/ctl_resp", tag), BLK_WIDTH'(ctl()), BLK_WIDTH'(3'b101));
        check($sformatf("%s/blk_resp", tag), resp_blk, t.exp_blk);
      end else begin
        check($sformatf("%s/ctl_idle", tag), BLK_WIDTH'(ctl()), BLK_WIDTH'(3'b010));
        check($sformatf("%s/blk_hold", tag), resp_blk, t.exp_blk);
      end
    end
  endtask

  initial begin
    txn_t t;
    // rd, wb, rd_addr, wb_addr, wb_blk, lat, expected resp_blk
    vecs[0] = '{1'b0, 1'b1, 16'h0000, 16'h0120, B_A5,   4, '0};
    vecs[1] = '{1'b1, 1'b0, 16'h0120, 16'h0000, '0,     4, B_A5};
    vecs[2] = '{1'b1, 1'b1, 16'h0340, 16'h0340, B_DEAD, 8, B_DEAD};
    vecs[3] = '{1'b1, 1'b0, 16'h0340, 16'h0000, '0,     4, B_DEAD};
    vecs[4] = '{1'b0, 1'b1, 16'h0000, 16'h0560, B_C3,   4, B_DEAD};
    vecs[5] = '{1'b1, 1'b0, 16'h0560, 16'h0000, '0,     4, B_C3};
    vecs[6] = '{1'b1, 1'b0, 16'h412F, 16'h0000, '0,     4, B_A5};
    vecs[7] = '{1'b0, 1'b1, 16'h0000, 16'hC78A, B_11,   4, B_A5};
    vecs[8] = '{1'b1, 1'b1, 16'h0120, 16'h0900, B_22,   8, B_A5};
    vecs[9] = '{1'b1, 1'b0, 16'h0905, 16'h0000, '0,     4, B_22};

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset/ctl", BLK_WIDTH'(ctl()), BLK_WIDTH'(3'b010));
    check("reset/blk", resp_blk, '0);

    for (int i = 0; i < 10; i++) begin
      run_txn(vecs[i], $sformatf("vec%0d", i));
    end

    // Request with neither flag set is ignored.
    req_valid = 1'b1;
    req_rd    = 1'b0;
    req_wb    = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("null/ctl%0d", k), BLK_WIDTH'(ctl()), BLK_WIDTH'(3'b010));
    end
    req_valid = 1'b0;

    // Write-back to block 0x078 aborted by reset before its commit edge.
    req_valid = 1'b1;
    req_wb    = 1'b1;
    req_rd    = 1'b0;
    wb_addr   = 16'h0780;
    wb_blk    = B_FF;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_wb    = 1'b0;
    check("abort/busy", BLK_WIDTH'(ctl()), BLK_WIDTH'(3'b001));
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort/rst_ctl", BLK_WIDTH'(ctl()), BLK_WIDTH'(3'b010));
    check("abort/rst_blk", resp_blk, '0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check($sformatf("abort/quiet%0d", k), BLK_WIDTH'(ctl()), BLK_WIDTH'(3'b010));
    end

    t = '{1'b1, 1'b0, 16'h0780, 16'h0000, '0, 4, B_11};
    run_txn(t, "abort_rd");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
